i2c_master_arbiter: RTL and testbench

- Shares one i2c_master instance between NUM_REQ independent requesters, e.g. a host-interface bridge, a sensor-init sequencer and a debug port.
- Arbitrates round-robin and latches the winner's chip/register address, data and direction.
- Drives the master's one-cycle we/re strobe and waits for done.
- Returns datao/status to the winner with a one-cycle done pulse; a watchdog aborts hung transactions.

---
 rtl/i2c_arb_pkg.sv | 8 +
 rtl/i2c_rr_pick.sv | 25 ++
 rtl/i2c_master_arbiter.sv | 119 +++++++++++
 tb/tb_i2c_master_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding, timeout status code and index-width helper for the i2c arbiter
package i2c_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  localparam logic [6:0] STATUS_TIMEOUT = 7'h7F;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker, first requester at or after ptr with wraparound
module i2c_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IW-1:0]      idx_o
);
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (req_i[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master between NUM_REQ requesters with watchdog abort
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_write_mode,
  input  logic [NUM_REQ*7-1:0]      req_chip_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_datai,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_datao,
  output logic [6:0]                rsp_status,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      arb_busy,
  output logic [6:0]                m_chip_addr,
  output logic [ADDR_W-1:0]         m_reg_addr,
  output logic [DATA_W-1:0]         m_datai,
  output logic                      m_we,
  output logic                      m_re,
  output logic                      m_write_mode,
  input  logic                      m_done,
  input  logic                      m_busy,
  input  logic [6:0]                m_status,
  input  logic [DATA_W-1:0]         m_datao
);
  localparam int IW = idx_w(NUM_REQ);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, ptr_q, ptr_d, pick_idx;
  logic [NUM_REQ-1:0] pick_gnt, grant_q;
  logic [31:0] wd_q;
  logic [6:0] chip_q, rsp_status_q;
  logic [ADDR_W-1:0] reg_q;
  logic [DATA_W-1:0] datai_q, rsp_datao_q;
  logic dir_q, we_q, re_q, wm_q, timeout;
  i2c_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(pick_gnt),
    .idx_o(pick_idx)
  );
  assign timeout = (TIMEOUT_CYCLES != 0) && (wd_q + 32'd1 == 32'(TIMEOUT_CYCLES));
  assign ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (|req && !m_busy) ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = (m_done || timeout) ? RESP : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      wd_q         <= '0;
      dir_q        <= 1'b0;
      we_q         <= 1'b0;
      re_q         <= 1'b0;
      wm_q         <= 1'b0;
      chip_q       <= '0;
      reg_q        <= '0;
      datai_q      <= '0;
      rsp_datao_q  <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      case (state_q)
        IDLE: if (state_d == ISSUE) begin
          // strobes are registered here so they appear for exactly the ISSUE cycle
          idx_q   <= pick_idx;
          grant_q <= pick_gnt;
          dir_q   <= req_we[pick_idx];
          we_q    <= req_we[pick_idx];
          re_q    <= !req_we[pick_idx];
          wm_q    <= req_write_mode[pick_idx];
          chip_q  <= req_chip_addr[int'(pick_idx)*7 +: 7];
          reg_q   <= req_reg_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          datai_q <= req_datai[int'(pick_idx)*DATA_W +: DATA_W];
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          wd_q <= wd_q + 32'd1;
          if (m_done) begin
            if (!dir_q) rsp_datao_q <= m_datao;
            rsp_status_q <= m_status;
          end else if (timeout) rsp_status_q <= STATUS_TIMEOUT;
        end
        default: begin
          ptr_q   <= ptr_d;
          grant_q <= '0;
        end
      endcase
    end
  end
  assign done         = (state_q == RESP) ? grant_q : '0;
  assign grant        = grant_q;
  assign arb_busy     = state_q != IDLE;
  assign rsp_datao    = rsp_datao_q;
  assign rsp_status   = rsp_status_q;
  assign m_chip_addr  = chip_q;
  assign m_reg_addr   = reg_q;
  assign m_datai      = datai_q;
  assign m_we         = we_q;
  assign m_re         = re_q;
  assign m_write_mode = wm_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: directed vector table plus hand sequences for round-robin, busy, timeout and reset
module tb_i2c_master_arbiter;
  localparam int N = 3, AW = 16, DW = 32;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [N-1:0] req = '0, req_we = '0, req_write_mode = '0;
  logic [N*7-1:0] req_chip_addr = '0;
  logic [N*AW-1:0] req_reg_addr = '0;
  logic [N*DW-1:0] req_datai = '0;
  logic [N-1:0] done, grant;
  logic [DW-1:0] rsp_datao, m_datai, m_datao;
  logic [6:0] rsp_status, m_chip_addr, m_status;
  logic [AW-1:0] m_reg_addr;
  logic arb_busy, m_we, m_re, m_write_mode, m_done, m_busy = 0;
  i2c_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_write_mode(req_write_mode),
    .req_chip_addr(req_chip_addr), .req_reg_addr(req_reg_addr), .req_datai(req_datai),
    .done(done), .rsp_datao(rsp_datao), .rsp_status(rsp_status), .grant(grant), .arb_busy(arb_busy),
    .m_chip_addr(m_chip_addr), .m_reg_addr(m_reg_addr), .m_datai(m_datai), .m_we(m_we), .m_re(m_re),
    .m_write_mode(m_write_mode), .m_done(m_done), .m_busy(m_busy), .m_status(m_status), .m_datao(m_datao)
  );
  int total = 0, bad = 0;
  int lat_cfg = 1;
  bit hang = 0;
  logic [31:0] mdata = '0;
  logic [6:0] mstat = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // master model: m_done pulses lat_cfg cycles after the strobe cycle unless hang is set
  initial begin
    int cnt;
    cnt = -1;
    m_done = 0;
    m_datao = '0;
    m_status = '0;
    forever begin
      @(posedge clk);
      #1;
      m_done = 0;
      if (cnt > 0) cnt--;
      if (cnt == 0) begin
        m_done = 1;
        m_datao = mdata;
        m_status = mstat;
        cnt = -1;
      end
      if ((m_we || m_re) && !hang) cnt = lat_cfg;
    end
  end
  task automatic run_txn(input int id, input bit we, input bit wm, input logic [6:0] chip,
                         input logic [15:0] ra, input logic [31:0] di, output int lat,
                         output logic [N-1:0] dv, output int nwe, output int nre,
                         output bit gok, output bit mok);
    req_we[id] = we;
    req_write_mode[id] = wm;
    req_chip_addr[id*7 +: 7] = chip;
    req_reg_addr[id*AW +: AW] = ra;
    req_datai[id*DW +: DW] = di;
    req[id] = 1;
    lat = 0; dv = '0; nwe = 0; nre = 0; gok = 1; mok = 1;
    for (int n = 1; n <= 200; n++) begin
      tick();
      nwe += int'(m_we);
      nre += int'(m_re);
      if (grant !== (N'(1) << id)) gok = 0;
      if (m_chip_addr !== chip || m_reg_addr !== ra || m_datai !== di || m_write_mode !== wm) mok = 0;
      if (done !== '0) begin
        dv = done;
        lat = n;
        break;
      end
    end
    req[id] = 0;
  endtask
  typedef struct {
    int id; bit we; bit wm; logic [6:0] chip; logic [15:0] ra; logic [31:0] di;
    logic [31:0] md; logic [6:0] ms; int l; int exp_lat; logic [31:0] exp_do; logic [6:0] exp_st;
  } vec_t;
  vec_t v[4];
  initial begin
    int lat, nwe, nre, got;
    logic [N-1:0] dv;
    bit gok, mok, ok;
    v[0] = '{0, 0, 0, 7'h50, 16'h0012, 32'h0, 32'hDEADBEEF, 7'h00, 10, 12, 32'hDEADBEEF, 7'h00};
    v[1] = '{2, 1, 1, 7'h3C, 16'hBEEF, 32'h12345678, 32'hAAAA5555, 7'h05, 3, 5, 32'hDEADBEEF, 7'h05};
    v[2] = '{1, 0, 0, 7'h21, 16'h0100, 32'h0, 32'h0BADF00D, 7'h11, 1, 3, 32'h0BADF00D, 7'h11};
    v[3] = '{1, 1, 0, 7'h7E, 16'hFFFF, 32'hCAFEF00D, 32'hFFFFFFFF, 7'h22, 2, 4, 32'h0BADF00D, 7'h22};
    repeat (3) tick();
    reset = 0;
    chk("rst_done", 64'(done), 0);
    chk("rst_grant", 64'(grant), 0);
    chk("rst_busy", 64'(arb_busy), 0);
    chk("rst_strobes", 64'({m_we, m_re}), 0);
    chk("rst_rsp", 64'({rsp_status, rsp_datao}), 0);
    chk("rst_m_addr", 64'({m_chip_addr, m_reg_addr}), 0);
    foreach (v[i]) begin
      lat_cfg = v[i].l; mdata = v[i].md; mstat = v[i].ms;
      run_txn(v[i].id, v[i].we, v[i].wm, v[i].chip, v[i].ra, v[i].di, lat, dv, nwe, nre, gok, mok);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(v[i].exp_lat));
      chk($sformatf("v%0d_done", i), 64'(dv), 64'(N'(1) << v[i].id));
      chk($sformatf("v%0d_we_count", i), 64'(nwe), 64'(v[i].we));
      chk($sformatf("v%0d_re_count", i), 64'(nre), 64'(!v[i].we));
      chk($sformatf("v%0d_grant_held", i), 64'(gok), 1);
      chk($sformatf("v%0d_m_stable", i), 64'(mok), 1);
      chk($sformatf("v%0d_rsp_datao", i), 64'(rsp_datao), 64'(v[i].exp_do));
      chk($sformatf("v%0d_rsp_status", i), 64'(rsp_status), 64'(v[i].exp_st));
      tick();
      chk($sformatf("v%0d_idle", i), 64'({grant, done, arb_busy}), 0);
    end
    hang = 1;
    run_txn(0, 0, 0, 7'h11, 16'h2222, 32'h0, lat, dv, nwe, nre, gok, mok);
    chk("to_latency", 64'(lat), 52);
    chk("to_done", 64'(dv), 64'(3'b001));
    chk("to_status", 64'(rsp_status), 64'(7'h7F));
    chk("to_datao_kept", 64'(rsp_datao), 64'(32'h0BADF00D));
    tick();
    hang = 0; lat_cfg = 1; mdata = 32'h13572468; mstat = 7'h03;
    run_txn(2, 0, 0, 7'h12, 16'h3333, 32'h0, lat, dv, nwe, nre, gok, mok);
    chk("after_to_latency", 64'(lat), 3);
    chk("after_to_datao", 64'(rsp_datao), 64'(32'h13572468));
    chk("after_to_status", 64'(rsp_status), 64'(7'h03));
    tick();
    req_we = '0; lat_cfg = 1; ok = 1;
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      got = -1;
      for (int n = 1; n <= 50; n++) begin
        tick();
        if ($countones(grant) > 1) ok = 0;
        if (done !== '0) begin
          got = done[0] ? 0 : done[1] ? 1 : 2;
          if (k == 5) req = '0; else req[got] = 0;
          break;
        end
      end
      chk($sformatf("rr_order%0d", k), 64'(got), 64'(k % 3));
      tick();
      if (k < 5 && got >= 0) req[got] = 1;
    end
    chk("rr_no_overlap", 64'(ok), 1);
    m_busy = 1; mdata = 32'h55AA55AA; mstat = 7'h00; ok = 1;
    req_we[1] = 0;
    req[1] = 1;
    repeat (20) begin
      tick();
      if (grant !== '0 || arb_busy || m_re || m_we) ok = 0;
    end
    chk("busy_hold_off", 64'(ok), 1);
    m_busy = 0;
    tick();
    chk("busy_grant", 64'(grant), 64'(3'b010));
    chk("busy_strobe", 64'(m_re), 1);
    dv = '0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done !== '0) begin dv = done; break; end
    end
    req[1] = 0;
    chk("busy_done", 64'(dv), 64'(3'b010));
    tick();
    hang = 1;
    req_we[0] = 0;
    req[0] = 1;
    repeat (3) tick();
    chk("rst_mid_busy", 64'(arb_busy), 1);
    reset = 1;
    req = '0;
    tick();
    reset = 0;
    chk("rst_mid_outputs", 64'({done, grant, arb_busy, m_we, m_re, m_chip_addr, rsp_status}), 0);
    chk("rst_mid_datao", 64'(rsp_datao), 0);
    ok = 1;
    repeat (5) begin
      tick();
      if (done !== '0) ok = 0;
    end
    chk("rst_mid_no_done", 64'(ok), 1);
    hang = 0; lat_cfg = 2; mdata = 32'h600DCAFE; mstat = 7'h01;
    run_txn(1, 0, 0, 7'h44, 16'h0042, 32'h0, lat, dv, nwe, nre, gok, mok);
    chk("post_rst_latency", 64'(lat), 4);
    chk("post_rst_done", 64'(dv), 64'(3'b010));
    chk("post_rst_datao", 64'(rsp_datao), 64'(32'h600DCAFE));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
